// File: rtl/fp_norm_pipe_if.sv
// rtl/fp_norm_pipe_if.sv - operand/result handshake bundle for fp_norm_pipe
interface fp_norm_pipe_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [EXP_W-1:0]  exp_in;
  logic [FRAC_W:0]   frac_in;
  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  exp_out;
  logic [FRAC_W-1:0] frac_out;
  logic              overflow;
  logic              underflow;
  logic              zero;
  logic              sticky_clr;
  logic              ovf_sticky;
  logic              unf_sticky;

  modport master (
    output in_valid, exp_in, frac_in, out_ready, sticky_clr,
    input  in_ready, out_valid, exp_out, frac_out, overflow, underflow, zero,
           ovf_sticky, unf_sticky
  );

  modport slave (
    input  in_valid, exp_in, frac_in, out_ready, sticky_clr,
    output in_ready, out_valid, exp_out, frac_out, overflow, underflow, zero,
           ovf_sticky, unf_sticky
  );
endinterface

// File: rtl/fp_norm_pipe.sv
// rtl/fp_norm_pipe.sv - two-stage float normalizer; NORM_SATURATE_EN makes overflow return infinity
module fp_norm_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_norm_pipe_if.slave bus
);
  localparam int N_W = $clog2(FRAC_W + 1);
  localparam int E_W = EXP_W + 2;

  logic              en;
  logic [N_W-1:0]    lead_n;
  logic              in_zero;

  logic              s1_valid;
  logic [EXP_W-1:0]  s1_exp;
  logic [FRAC_W:0]   s1_frac;
  logic [N_W-1:0]    s1_n;
  logic              s1_zero;

  logic [E_W-1:0]    e_val;
  logic              e_unf;
  logic              e_ovf;
  logic [EXP_W-1:0]  nx_exp;
  logic [FRAC_W-1:0] nx_frac;
  logic              nx_ovf;
  logic              nx_unf;
  logic              nx_zero;

  logic              r_out_valid;
  logic [EXP_W-1:0]  r_exp;
  logic [FRAC_W-1:0] r_frac;
  logic              r_ovf;
  logic              r_unf;
  logic              r_zero;
  logic              r_ovf_sticky;
  logic              r_unf_sticky;

  assign en           = ~r_out_valid | bus.out_ready;
  assign bus.in_ready = en;

  // Ascending scan so the highest set bit wins
  always_comb begin
    lead_n  = '0;
    in_zero = ~|bus.frac_in;
    for (int i = 0; i <= FRAC_W; i++) begin
      if (bus.frac_in[i]) lead_n = N_W'(FRAC_W - i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_n     <= '0;
      s1_zero  <= 1'b0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s1_exp   <= bus.exp_in;
      s1_frac  <= bus.frac_in;
      s1_n     <= lead_n;
      s1_zero  <= in_zero;
    end
  end

  assign e_val = {2'b00, s1_exp} + E_W'(1) - E_W'(s1_n);
  assign e_unf = e_val[E_W-1] | (e_val == '0);
  assign e_ovf = ~e_val[E_W-1] & (e_val >= {2'b00, {EXP_W{1'b1}}});

  always_comb begin
    nx_exp  = e_val[EXP_W-1:0];
    nx_frac = FRAC_W'((s1_frac << s1_n) >> 1);
    nx_ovf  = 1'b0;
    nx_unf  = 1'b0;
    nx_zero = 1'b0;
    if (s1_zero) begin
      nx_zero = 1'b1;
      nx_exp  = '0;
      nx_frac = '0;
    end else if (e_unf) begin
      nx_unf  = 1'b1;
      nx_exp  = '0;
      nx_frac = '0;
    end else if (e_ovf) begin
      nx_ovf  = 1'b1;
`ifdef NORM_SATURATE_EN
      nx_exp  = '1;
`else
      nx_exp  = '0;
`endif
      nx_frac = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_exp       <= '0;
      r_frac      <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (en) begin
      r_out_valid <= s1_valid;
      r_exp       <= nx_exp;
      r_frac      <= nx_frac;
      r_ovf       <= nx_ovf;
      r_unf       <= nx_unf;
      r_zero      <= nx_zero;
    end
  end

  // A flag landing on the same edge as a clear must survive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
      r_unf_sticky <= 1'b0;
    end else begin
      r_ovf_sticky <= (r_ovf_sticky & ~bus.sticky_clr) | (r_out_valid & bus.out_ready & r_ovf);
      r_unf_sticky <= (r_unf_sticky & ~bus.sticky_clr) | (r_out_valid & bus.out_ready & r_unf);
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.exp_out    = r_exp;
  assign bus.frac_out   = r_frac;
  assign bus.overflow   = r_ovf;
  assign bus.underflow  = r_unf;
  assign bus.zero       = r_zero;
  assign bus.ovf_sticky = r_ovf_sticky;
  assign bus.unf_sticky = r_unf_sticky;
endmodule

// File: tb/tb_fp_norm_pipe.sv
// tb/tb_fp_norm_pipe.sv - directed vector bench for fp_norm_pipe (honours NORM_SATURATE_EN)
module tb_fp_norm_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_norm_pipe_if #(.EXP_W(8), .FRAC_W(24)) bus ();
  fp_norm_pipe #(.EXP_W(8), .FRAC_W(24)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef NORM_SATURATE_EN
  localparam logic [7:0] OVF_E = 8'hFF;
`else
  localparam logic [7:0] OVF_E = 8'h00;
`endif

  typedef struct {
    logic [7:0]  e;
    logic [24:0] f;
    logic [7:0]  xe;
    logic [23:0] xf;
    logic [2:0]  xflags;
  } vec_t;

  vec_t vec [13];
  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i);
    bus.in_valid = 1'b1;
    bus.exp_in   = vec[i].e;
    bus.frac_in  = vec[i].f;
  endtask

  initial begin
    int idx_in, got, cyc;
    logic [34:0] held;

    // {ovf,unf,zero}
    vec[0]  = '{8'h7F, 25'h1000000, 8'h80,  24'h800000, 3'b000};
    vec[1]  = '{8'h7F, 25'h0800000, 8'h7F,  24'h800000, 3'b000};
    vec[2]  = '{8'h40, 25'h0000003, 8'h2A,  24'hC00000, 3'b000};
    vec[3]  = '{8'h50, 25'h0000005, 8'h3B,  24'hA00000, 3'b000};
    vec[4]  = '{8'h00, 25'h1FFFFFF, 8'h01,  24'hFFFFFF, 3'b000};
    vec[5]  = '{8'hFF, 25'h0000000, 8'h00,  24'h000000, 3'b001};
    vec[6]  = '{8'h01, 25'h0000001, 8'h00,  24'h000000, 3'b010};
    vec[7]  = '{8'h17, 25'h0000001, 8'h00,  24'h000000, 3'b010};
    vec[8]  = '{8'h18, 25'h0000001, 8'h01,  24'h800000, 3'b000};
    vec[9]  = '{8'hFD, 25'h1000000, 8'hFE,  24'h800000, 3'b000};
    vec[10] = '{8'hFE, 25'h1000000, OVF_E,  24'h000000, 3'b100};
    vec[11] = '{8'hFF, 25'h0800000, OVF_E,  24'h000000, 3'b100};
    vec[12] = '{8'hFE, 25'h0800000, 8'hFE,  24'h800000, 3'b000};

    bus.in_valid = 1'b0; bus.exp_in = '0; bus.frac_in = '0;
    bus.out_ready = 1'b1; bus.sticky_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_data", {bus.exp_out, bus.frac_out, bus.overflow, bus.underflow, bus.zero}, 0);
    chk("rst_sticky", {bus.ovf_sticky, bus.unf_sticky}, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(i);
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_latency", i), bus.out_valid, 0);
      tick();
      chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("v%0d_exp", i), bus.exp_out, vec[i].xe);
      chk($sformatf("v%0d_frac", i), bus.frac_out, vec[i].xf);
      chk($sformatf("v%0d_flags", i), {bus.overflow, bus.underflow, bus.zero}, vec[i].xflags);
    end
    tick();
    chk("sticky_both_set", {bus.ovf_sticky, bus.unf_sticky}, 2'b11);

    // Back-to-back stream with a three-cycle downstream stall
    idx_in = 0; got = 0; cyc = 0; held = '0;
    while (got < 4 && cyc < 40) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      bus.in_valid  = (idx_in < 4);
      if (idx_in < 4) begin
        bus.exp_in  = vec[idx_in].e;
        bus.frac_in = vec[idx_in].f;
      end
      #1;
      if (!bus.out_ready && bus.out_valid) begin
        chk($sformatf("stall_in_ready_c%0d", cyc), bus.in_ready, 0);
        if (cyc > 3)
          chk($sformatf("stall_hold_c%0d", cyc),
              {bus.exp_out, bus.frac_out, bus.overflow, bus.underflow, bus.zero}, held);
        held = {bus.exp_out, bus.frac_out, bus.overflow, bus.underflow, bus.zero};
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("stream%0d_exp", got), bus.exp_out, vec[got].xe);
        chk($sformatf("stream%0d_frac", got), bus.frac_out, vec[got].xf);
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx_in++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_count", got, 4);

    // Reset with two operands in flight
    tick();
    drive(0);
    tick();
    drive(1);
    tick();
    bus.in_valid = 1'b0;
    chk("inflight_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_data", {bus.exp_out, bus.frac_out, bus.overflow, bus.underflow, bus.zero}, 0);
    chk("arst_sticky", {bus.ovf_sticky, bus.unf_sticky}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("no_stale_c%0d", c), bus.out_valid, 0);
    end

    // Set on the same edge as clear keeps the flag
    drive(6);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("unf_pending", {bus.out_valid, bus.underflow, bus.unf_sticky}, 3'b110);
    bus.sticky_clr = 1'b1;
    tick();
    chk("unf_set_wins", bus.unf_sticky, 1);
    tick();
    bus.sticky_clr = 1'b0;
    chk("unf_cleared", bus.unf_sticky, 0);

    drive(10);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("ovf_sticky_set", {bus.ovf_sticky, bus.unf_sticky}, 2'b10);
    bus.sticky_clr = 1'b1;
    tick();
    bus.sticky_clr = 1'b0;
    chk("ovf_cleared", bus.ovf_sticky, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
